// File: rtl/inst_fetch_rsp_pkg.sv
// rtl/inst_fetch_rsp_pkg.sv - shared bus constants, FSM state type and helpers for inst_fetch_rsp
package inst_fetch_rsp_pkg;

  // Bus widths and reset/idle words shared with the rest of the core
  localparam int                       INST_ADDR_BUS = 32;
  localparam int                       INST_BUS      = 32;
  localparam logic [INST_ADDR_BUS-1:0] INST_ADDR_NOP = '0;
  localparam logic [INST_BUS-1:0]      INST_NOP_WORD = 32'h0000_0013;

  // Active levels of the control-unit and PC-register strobes
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic JUMP_ENABLE = 1'b1;
  localparam logic RST_ENABLE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  // A fetch is misaligned when the byte offset within the word is non-zero
  function automatic logic misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_rsp_if.sv
// rtl/inst_fetch_rsp_if.sv - instruction-fetch request/response bus between PC register and fetch responder
interface inst_fetch_rsp_if;
  import inst_fetch_rsp_pkg::*;

  logic                     ce_i;
  logic [INST_ADDR_BUS-1:0] pc_i;
  logic [INST_BUS-1:0]      inst_o;
  logic [INST_ADDR_BUS-1:0] inst_addr_o;
  logic                     inst_valid_o;
  logic                     hold_req_o;
  logic                     fault_o;

  // PC register side
  modport master (
    output ce_i, pc_i,
    input  inst_o, inst_addr_o, inst_valid_o, hold_req_o, fault_o
  );

  // Fetch responder side
  modport slave (
    input  ce_i, pc_i,
    output inst_o, inst_addr_o, inst_valid_o, hold_req_o, fault_o
  );

endinterface

// File: rtl/inst_fetch_rsp_mem.sv
// rtl/inst_fetch_rsp_mem.sv - inst_mem_array: synchronous 1R1W word memory, read-before-write
module inst_mem_array #(
  parameter int DEPTH_LOG2 = 12,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rd_data_q;

  // Read register only moves on a read so it keeps the last fetched word; a same-edge write is seen next read
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_fetch_rsp.sv
// rtl/inst_fetch_rsp.sv - instruction-fetch responder with wait states, flush and PC hold; optional IFETCH_MISALIGN_CHK_EN
module inst_fetch_rsp
  import inst_fetch_rsp_pkg::*;
#(
  parameter int                  WAIT_CYCLES = 2,
  parameter int                  DEPTH_LOG2  = 12,
  parameter logic [INST_BUS-1:0] INST_NOP    = INST_NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_fetch_rsp_if.slave       ifetch,
  input  logic                  flush_i,
  input  logic                  ld_we_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [INST_BUS-1:0]   ld_data_i
);

  fetch_state_e             state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [INST_ADDR_BUS-1:0] addr_q, addr_d;
  logic [INST_ADDR_BUS-1:0] inst_addr_q, inst_addr_d;
  logic                     fault_q, fault_d;
  logic                     nop_sel_q, nop_sel_d;

  logic                     active;
  logic                     rd_en;
  logic                     rd_misalign;
  logic [INST_ADDR_BUS-1:0] rd_addr;
  logic [INST_BUS-1:0]      mem_rdata;

  assign active = (ifetch.ce_i == CHIP_ENABLE) && (flush_i != JUMP_ENABLE);

  // A zero-wait fetch reads straight from pc_i at the accept edge; otherwise from the captured address
  assign rd_addr = (state_q == ST_IDLE) ? ifetch.pc_i : addr_q;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign rd_misalign = misaligned(rd_addr[1:0]);
`else
  assign rd_misalign = 1'b0;
`endif

  // Next-state, wait counter and response-register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    inst_addr_d = inst_addr_q;
    fault_d     = fault_q;
    nop_sel_d   = nop_sel_q;
    rd_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (active) begin
          addr_d = ifetch.pc_i;
          if (WAIT_CYCLES == 0) begin
            rd_en   = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!active) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          rd_en   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rd_en) begin
      inst_addr_d = rd_addr;
      fault_d     = rd_misalign;
      nop_sel_d   = rd_misalign;
    end
  end

  // State and response registers; nop_sel starts set so inst_o shows the NOP word out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= INST_ADDR_NOP;
      inst_addr_q <= INST_ADDR_NOP;
      fault_q     <= 1'b0;
      nop_sel_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      inst_addr_q <= inst_addr_d;
      fault_q     <= fault_d;
      nop_sel_q   <= nop_sel_d;
    end
  end

  inst_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (INST_BUS)
  ) u_mem (
    .clk       (clk),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr[DEPTH_LOG2+1:2]),
    .rd_data_o (mem_rdata),
    .wr_en_i   (ld_we_i),
    .wr_addr_i (ld_addr_i),
    .wr_data_i (ld_data_i)
  );

  assign ifetch.hold_req_o   = active && (state_q != ST_RESP);
  assign ifetch.inst_valid_o = active && (state_q == ST_RESP);
  assign ifetch.inst_o       = nop_sel_q ? INST_NOP : mem_rdata;
  assign ifetch.inst_addr_o  = inst_addr_q;
  assign ifetch.fault_o      = fault_q;

endmodule

// File: tb/tb_inst_fetch_rsp.sv
// tb/tb_inst_fetch_rsp.sv - self-checking bench for inst_fetch_rsp with a transaction-level reference model
module tb_inst_fetch_rsp;

  localparam int          W     = 2;
  localparam int          DLOG  = 12;
  localparam int          DEPTH = 1 << DLOG;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ce = 1'b0;
  logic [31:0]     pc = '0;
  logic            flush = 1'b0;
  logic            ld_we = 1'b0;
  logic [DLOG-1:0] ld_addr = '0;
  logic [31:0]     ld_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch_rsp_if dut_if ();
  assign dut_if.ce_i = ce;
  assign dut_if.pc_i = pc;

  inst_fetch_rsp #(.WAIT_CYCLES(W), .DEPTH_LOG2(DLOG), .INST_NOP(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifetch    (dut_if),
    .flush_i   (flush),
    .ld_we_i   (ld_we),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: one fetch transaction tracked by its age ----------------
  logic [31:0] mmem [0:DEPTH-1];
  bit          m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_acc = 0;
  logic [31:0] m_fetch_addr = '0;
  logic [31:0] m_inst = NOP;
  logic [31:0] m_addr = '0;
  logic        m_fault = 1'b0;

  always @(posedge clk) begin
    bit          act, do_read;
    logic [31:0] ra, word;
    bit          mis;
    act = ce && !flush;
    do_read = 1'b0;
    ra = m_fetch_addr;
    if (rst) begin
      m_busy  = 1'b0;
      m_cyc   = 0;
      m_inst  = NOP;
      m_addr  = '0;
      m_fault = 1'b0;
    end else begin
      if (m_busy) begin
        if (!act) m_busy = 1'b0;
        else if (m_cyc - m_acc == W) m_busy = 1'b0;
        else if (m_cyc - m_acc == W - 1) do_read = 1'b1;
      end else if (act) begin
        m_busy = 1'b1;
        m_acc = m_cyc + 1;
        m_fetch_addr = pc;
        ra = pc;
        if (W == 0) do_read = 1'b1;
      end
      if (do_read) begin
        word    = mmem[int'((ra / 4) % DEPTH)];
        mis     = MIS_EN && (ra % 4 != 0);
        m_inst  = mis ? NOP : word;
        m_addr  = ra;
        m_fault = mis;
      end
      m_cyc++;
    end
    if (ld_we) mmem[ld_addr] = ld_data;
  end

  // ---------------- compare process: every cycle, away from the active edge ----------------
  always @(negedge clk) begin
    bit act, resp;
    act  = ce && !flush;
    resp = m_busy && (m_cyc - m_acc == W);
    chk1("hold_req_o", dut_if.hold_req_o, act && !resp);
    chk1("inst_valid_o", dut_if.inst_valid_o, act && resp);
    chk32("inst_o", dut_if.inst_o, m_inst);
    chk32("inst_addr_o", dut_if.inst_addr_o, m_addr);
    chk1("fault_o", dut_if.fault_o, m_fault);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output bit seen, output int k, output int holds,
                             output logic [31:0] inst, output logic [31:0] addr, output logic f);
    seen = 1'b0; k = -1; holds = 0; inst = '0; addr = '0; f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut_if.inst_valid_o) begin
        seen = 1'b1; k = i;
        inst = dut_if.inst_o; addr = dut_if.inst_addr_o; f = dut_if.fault_o;
        break;
      end
      if (dut_if.hold_req_o) holds++;
      tick();
    end
  endtask

  bit          seen;
  int          k, holds, nstb;
  logic [31:0] r_inst, r_addr, r;
  logic        r_f;
  int          t_stb [3];
  logic [31:0] i_stb [3];
  logic [31:0] a_stb [3];
  logic [31:0] exp_mis_inst;
  logic        exp_mis_fault;
  logic [1:0]  lsb;
  bit          v;

  initial begin
    // Reset, then PC register held in reset (ce low)
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk32("rst_inst", dut_if.inst_o, 32'h13);
    chk1("rst_valid", dut_if.inst_valid_o, 1'b0);
    chk1("rst_hold", dut_if.hold_req_o, 1'b0);
    tick();

    // Preload words 0..63 with a few known values
    for (int i = 0; i < 64; i++) begin
      ld_we = 1'b1;
      ld_addr = DLOG'(i);
      case (i)
        0: ld_data = 32'h1111_0000;
        1: ld_data = 32'hDEAD_BEEF;
        2: ld_data = 32'h2222_0002;
        5: ld_data = 32'h5555_0005;
        16: ld_data = 32'h0000_1616;
        default: ld_data = $urandom();
      endcase
      tick();
    end
    ld_we = 1'b0;
    tick();

    // Basic fetch from 0x4
    pc = 32'h4; ce = 1'b1;
    wait_strobe(seen, k, holds, r_inst, r_addr, r_f);
    chk1("basic_seen", seen, 1'b1);
    chk32("basic_latency", 32'(k), 32'd3);
    chk32("basic_hold_cycles", 32'(holds), 32'd3);
    chk32("basic_inst", r_inst, 32'hDEAD_BEEF);
    chk32("basic_addr", r_addr, 32'h4);
    tick(); ce = 1'b0; tick();

    // Back-to-back: PC register steps by 4 at the edge that ends each response
    pc = 32'h0; ce = 1'b1; nstb = 0;
    for (int i = 0; i < 3; i++) begin t_stb[i] = 0; i_stb[i] = '0; a_stb[i] = '0; end
    for (int c = 0; c < 40 && nstb < 3; c++) begin
      @(negedge clk);
      v = dut_if.inst_valid_o;
      if (v) begin
        t_stb[nstb] = c; i_stb[nstb] = dut_if.inst_o; a_stb[nstb] = dut_if.inst_addr_o; nstb++;
      end
      tick();
      if (v) pc = pc + 32'd4;
    end
    ce = 1'b0;
    chk32("b2b_count", 32'(nstb), 32'd3);
    chk32("b2b_gap1", 32'(t_stb[1] - t_stb[0]), 32'd4);
    chk32("b2b_gap2", 32'(t_stb[2] - t_stb[1]), 32'd4);
    chk32("b2b_inst0", i_stb[0], 32'h1111_0000);
    chk32("b2b_inst1", i_stb[1], 32'hDEAD_BEEF);
    chk32("b2b_inst2", i_stb[2], 32'h2222_0002);
    chk32("b2b_addr2", a_stb[2], 32'h8);
    tick();

    // Flush during the wait phase, then jump target 0x40
    pc = 32'h8; ce = 1'b1;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk1("flush_hold", dut_if.hold_req_o, 1'b0);
    chk1("flush_valid", dut_if.inst_valid_o, 1'b0);
    tick();
    flush = 1'b0; pc = 32'h40;
    wait_strobe(seen, k, holds, r_inst, r_addr, r_f);
    chk1("flush_seen", seen, 1'b1);
    chk32("flush_addr", r_addr, 32'h40);
    chk32("flush_inst", r_inst, 32'h0000_1616);
    tick(); ce = 1'b0; tick();

    // Load collision on the read edge returns old data; the refetch sees the new word
    pc = 32'h14; ce = 1'b1;
    tick();
    tick();
    ld_we = 1'b1; ld_addr = DLOG'(5); ld_data = 32'hC0FF_EE05;
    tick();
    ld_we = 1'b0;
    @(negedge clk);
    chk1("coll_valid", dut_if.inst_valid_o, 1'b1);
    chk32("coll_old", dut_if.inst_o, 32'h5555_0005);
    tick();
    wait_strobe(seen, k, holds, r_inst, r_addr, r_f);
    chk1("coll_re_seen", seen, 1'b1);
    chk32("coll_new", r_inst, 32'hC0FF_EE05);
    tick(); ce = 1'b0; tick();

    // Misaligned fetch
`ifdef IFETCH_MISALIGN_CHK_EN
    exp_mis_inst = 32'h13; exp_mis_fault = 1'b1;
`else
    exp_mis_inst = 32'hDEAD_BEEF; exp_mis_fault = 1'b0;
`endif
    pc = 32'h6; ce = 1'b1;
    wait_strobe(seen, k, holds, r_inst, r_addr, r_f);
    chk1("mis_seen", seen, 1'b1);
    chk32("mis_inst", r_inst, exp_mis_inst);
    chk1("mis_fault", r_f, exp_mis_fault);
    chk32("mis_addr", r_addr, 32'h6);
    tick(); ce = 1'b0; tick();

    // Randomised traffic: wrapping high address bits, odd offsets, flushes, ce drops, loads
    for (int i = 0; i < 800; i++) begin
      r = $urandom();
      lsb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pc = {r[31:14], 6'b0, 6'($urandom_range(0, 63)), lsb};
      ce = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 11) == 0);
      ld_we = ($urandom_range(0, 9) == 0);
      ld_addr = DLOG'($urandom_range(0, 63));
      ld_data = $urandom();
      tick();
    end
    ce = 1'b0; flush = 1'b0; ld_we = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_rsp.md
# inst_fetch_rsp

Responder end of the instruction-fetch interface: accepts the PC and chip-enable issued by the PC register, reads a word-addressed instruction memory with a configurable number of wait states, and returns the instruction with a one-cycle valid strobe. While a fetch is in flight it raises a hold request that feeds the `HoldPc` bit of the hold-flag bus, so the PC is frozen until the word is delivered. A jump from the control unit flushes any in-flight fetch.

## Interface
- `WAIT_CYCLES`, 2, memory wait states per fetch (0..15).
- `DEPTH_LOG2`, 12, log2 of memory depth in 32-bit words.
- `INST_NOP`, 32'h0000_0013, word driven when no valid instruction is available.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce_i`  in  1  chip enable from PC register; low means PC register is in reset.
- `pc_i`  in  32  byte address of the requested instruction (`InstAddrBus`).
- `flush_i`  in  1  jump flag; abandons the current fetch.
- `ld_we_i`  in  1  load-port write enable.
- `ld_addr_i`  in  DEPTH_LOG2  load-port word address.
- `ld_data_i`  in  32  load-port write data.
- `inst_o`  out  32  fetched instruction (`InstBus`).
- `inst_addr_o`  out  32  byte address `inst_o` was fetched from.
- `inst_valid_o`  out  1  one-cycle strobe: `inst_o`/`inst_addr_o` valid.
- `hold_req_o`  out  1  request to freeze the PC.
- `fault_o`  out  1  misaligned-fetch flag, qualified by `inst_valid_o`.

## Operation
- States: IDLE, WAIT, RESP. Wait counter `cnt` is 4 bits.
- IDLE: if `ce_i && !flush_i`: capture `addr_q <= pc_i`, `cnt <= WAIT_CYCLES`, go WAIT. If `WAIT_CYCLES==0`, go directly to RESP with the memory read issued at the same edge.
- WAIT: `cnt` decrements every edge. When `cnt==1`, the memory read is issued at that edge and the state goes to RESP.
- RESP: `inst_valid_o=1` for exactly one cycle. Go IDLE.
- `hold_req_o` is combinational: 1 when (IDLE && `ce_i` && `!flush_i`) or WAIT; 0 in RESP. The PC therefore advances at the edge that ends RESP.
- Memory index is `addr_q[DEPTH_LOG2+1:2]`. Higher address bits are ignored, so addresses wrap modulo depth.
- `flush_i` in IDLE or WAIT: fetch is dropped and the state is or returns to IDLE; no strobe.
- `flush_i` in RESP: `inst_valid_o` is gated to 0 and the state goes to IDLE.
- `ce_i` low in any state: go to IDLE, no strobe, `hold_req_o=0`.
- Load port writes at the rising edge when `ld_we_i=1`. It is independent of the FSM.
- A load to the word being read at the same edge returns the old data (read-before-write).
- Reset values: state IDLE, `cnt=0`, `addr_q=0`, `inst_o=INST_NOP`, `inst_addr_o=0`, `inst_valid_o=0`, `fault_o=0`. `hold_req_o=0` after reset while `ce_i` is low.
- Memory contents are not reset.

## Timing
- Accept edge to `inst_valid_o` high: WAIT_CYCLES+1 cycles.
- Throughput: one instruction per WAIT_CYCLES+2 cycles. With `WAIT_CYCLES=0`, that is one every 2 cycles.
- `inst_o` and `inst_addr_o` are registered and hold their last value after RESP until the next RESP.
- `flush_i` takes effect in the same cycle: combinational on strobe and hold, registered on state.

## Configuration
- `IFETCH_MISALIGN_CHK_EN` defined:
  - In RESP, if `addr_q[1:0]!=0`, then `fault_o=1` and `inst_o=INST_NOP`.
  - `inst_addr_o` still reports the faulting address.
- Undefined: `addr_q[1:0]` is ignored and `fault_o` is tied to 0.

## Structure
- Shared constants come from `defines.v`: `InstAddrBus`, `InstBus`, `InstAddrNop`, `ChipEnable`, `JumpEnable`, `HoldPc`, `RstEnable`.
- Add `InstNop` to `defines.v` and use it as the default for `INST_NOP`.
- One sub-module, `inst_mem_array`: synchronous 1R1W memory, read-before-write, parameterised by `DEPTH_LOG2`.
- FSM, counter, flush and hold logic live in `inst_fetch_rsp`.

## Test plan
- Reset/ce: `rst=1`, then `ce_i=0` for 3 cycles -> `inst_o=32'h13`, `inst_valid_o=0`, `hold_req_o=0`.
- Basic fetch, `WAIT_CYCLES=2`: preload word 1 = 32'hDEAD_BEEF; `pc_i=32'h4`, `ce_i=1` -> `hold_req_o=1` for 3 cycles; `inst_valid_o` pulses on the 3rd cycle after accept with `inst_o=32'hDEAD_BEEF`, `inst_addr_o=32'h4`.
- Back-to-back fetches: pc register model steps 0, 4, 8 -> three strobes spaced 4 cycles apart, data matching words 0, 1, 2.
- Flush: `flush_i` pulsed in WAIT, then `pc_i=32'h40` -> no strobe for the old fetch; next strobe returns word 16 with `inst_addr_o=32'h40`.
- Load collision: `ld_we_i` targets the word being read at the read edge -> old data returned; a refetch returns the new data.
- Misalign, macro defined: `pc_i=32'h6` -> strobe with `fault_o=1`, `inst_o=32'h13`. Macro undefined -> word 1 returned and `fault_o=0`.
